pcie_tlp_tx_fwd: RTL

//  Downstream of the Ethernet decap stage on the PCIe side. Reads TLP entries (PCIE_FIFO64_TX)

---
 rtl/pcie_tlp_tx_fwd.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/pcie_tlp_tx_fwd.sv
// pcie_tlp_tx_fwd
//   Store-and-forward TLP forwarder between the clock-crossing TLP FIFO (FWFT) and the
//   7-series PCIe core TX AXI-Stream port. A packet is started only after the decap stage
//   has announced it complete (pkt_ready), bubble entries are discarded, and FIFO-full
//   abort entries are turned into a discontinue beat.
//
//   Ports
//     pcie_clk, pcie_rst     clock, synchronous active-high reset
//     rd_en                  FIFO pop (combinational; dout is the head while !empty)
//     dout[78:0]             {data_valid, tvalid, tlast, tkeep[7:0], tdata[63:0], tuser[3:0]}
//     empty                  FIFO empty
//     pkt_ready              one pulse per complete packet written into the FIFO
//     s_axis_tx_*            registered AXI-Stream TX beat towards the PCIe core
//     pkt_cnt_ovf            sticky: pkt_ready seen while the packet counter was saturated
//     tx_pkt_count           accepted tlast beats        (TLP_TX_STATS_EN, else tied to 0)
//     tx_discont_count       accepted discontinue beats  (TLP_TX_STATS_EN, else tied to 0)
//
//   Optional feature macro: TLP_TX_STATS_EN
module pcie_tlp_tx_fwd #(
    parameter int unsigned CNT_W = 8
) (
    input  logic        pcie_clk,
    input  logic        pcie_rst,
    output logic        rd_en,
    input  logic [78:0] dout,
    input  logic        empty,
    input  logic        pkt_ready,
    input  logic        s_axis_tx_tready,
    output logic        s_axis_tx_tvalid,
    output logic        s_axis_tx_tlast,
    output logic [7:0]  s_axis_tx_tkeep,
    output logic [63:0] s_axis_tx_tdata,
    output logic [3:0]  s_axis_tx_tuser,
    output logic        pkt_cnt_ovf,
    output logic [31:0] tx_pkt_count,
    output logic [31:0] tx_discont_count
);

    localparam int unsigned DV_BIT   = 78;
    localparam int unsigned TV_BIT   = 77;
    localparam int unsigned TL_BIT   = 76;
    localparam int unsigned KEEP_LSB = 68;
    localparam int unsigned DATA_LSB = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic               ovf_q, ovf_d;
    logic               tvalid_q, tvalid_d;
    logic               tlast_q, tlast_d;
    logic [7:0]         tkeep_q, tkeep_d;
    logic [63:0]        tdata_q, tdata_d;
    logic               tdiscont_q, tdiscont_d;

    // Head entry decode
    logic        head_dv, head_tv, head_tl;
    logic [7:0]  head_keep;
    logic [63:0] head_data;
    logic        head_is_data, head_is_bubble, head_is_abort;
    logic        load_ok, pop_data, pop_last;
    logic        unused_head_tuser;

    assign head_dv           = dout[DV_BIT];
    assign head_tv           = dout[TV_BIT];
    assign head_tl           = dout[TL_BIT];
    assign head_keep         = dout[KEEP_LSB +: 8];
    assign head_data         = dout[DATA_LSB +: 64];
    // Incoming tuser is not forwarded; only the discontinue bit is generated here.
    assign unused_head_tuser = ^dout[3:0];

    assign head_is_data   = !empty && head_dv;
    assign head_is_bubble = !empty && !head_dv;
    assign head_is_abort  = !head_tv && head_tl;
    assign load_ok        = !tvalid_q || s_axis_tx_tready;

    // Next-state, pop decision, output register load and packet counter
    always_comb begin
        state_d    = state_q;
        pkt_cnt_d  = pkt_cnt_q;
        ovf_d      = ovf_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        tkeep_d    = tkeep_q;
        tdata_d    = tdata_q;
        tdiscont_d = tdiscont_q;
        pop_data   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Entering STREAM costs one cycle; the first pop happens from STREAM.
                if ((pkt_cnt_q != '0) && head_is_data) begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (head_is_data && load_ok) begin
                    pop_data = 1'b1;
                    if (head_tl) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        pop_last = pop_data && head_tl;
        // Bubbles are drained regardless of state or back-pressure.
        rd_en    = head_is_bubble || pop_data;

        if (load_ok) begin
            tvalid_d = 1'b0;
        end
        if (pop_data) begin
            tvalid_d = 1'b1;
            if (head_is_abort) begin
                tlast_d    = 1'b1;
                tkeep_d    = 8'h00;
                tdata_d    = 64'h0;
                tdiscont_d = 1'b1;
            end else begin
                tlast_d    = head_tl;
                tkeep_d    = head_keep;
                tdata_d    = head_data;
                tdiscont_d = 1'b0;
            end
        end

        // A coincident announce and tlast pop cancel out.
        if (pkt_ready && !pop_last) begin
            if (pkt_cnt_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
            end
        end else if (!pkt_ready && pop_last && (pkt_cnt_q != '0)) begin
            pkt_cnt_d = pkt_cnt_q - CNT_W'(1);
        end
    end

    // State and output registers
    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            state_q    <= S_IDLE;
            pkt_cnt_q  <= '0;
            ovf_q      <= 1'b0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tkeep_q    <= 8'h00;
            tdata_q    <= 64'h0;
            tdiscont_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pkt_cnt_q  <= pkt_cnt_d;
            ovf_q      <= ovf_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            tkeep_q    <= tkeep_d;
            tdata_q    <= tdata_d;
            tdiscont_q <= tdiscont_d;
        end
    end

    assign s_axis_tx_tvalid = tvalid_q;
    assign s_axis_tx_tlast  = tlast_q;
    assign s_axis_tx_tkeep  = tkeep_q;
    assign s_axis_tx_tdata  = tdata_q;
    assign s_axis_tx_tuser  = {tdiscont_q, 3'b000};
    assign pkt_cnt_ovf      = ovf_q;

`ifdef TLP_TX_STATS_EN
    logic [31:0] stat_pkt_q, stat_pkt_d;
    logic [31:0] stat_disc_q, stat_disc_d;
    logic        beat_accept;

    assign beat_accept = tvalid_q && s_axis_tx_tready;

    // Accepted-beat statistics, free-running with natural wrap
    always_comb begin
        stat_pkt_d  = stat_pkt_q;
        stat_disc_d = stat_disc_q;
        if (beat_accept && tlast_q) begin
            stat_pkt_d = stat_pkt_q + 32'd1;
        end
        if (beat_accept && tdiscont_q) begin
            stat_disc_d = stat_disc_q + 32'd1;
        end
    end

    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            stat_pkt_q  <= 32'd0;
            stat_disc_q <= 32'd0;
        end else begin
            stat_pkt_q  <= stat_pkt_d;
            stat_disc_q <= stat_disc_d;
        end
    end

    assign tx_pkt_count     = stat_pkt_q;
    assign tx_discont_count = stat_disc_q;
`else
    assign tx_pkt_count     = 32'd0;
    assign tx_discont_count = 32'd0;
`endif

endmodule
